// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector memory responder.
//   VM_DATA_WIDTH : default word width (processor memory data bus)
//   ERR_CNT_W     : width of the saturating bad-request counter
//   rsp_t         : one read-response pipeline stage {valid, err, data}
//   addr_ok()     : word alignment plus range check of a byte address
package vec_mem_pkg;

    localparam int VM_DATA_WIDTH = 32;
    localparam int ERR_CNT_W     = 8;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [VM_DATA_WIDTH-1:0] data;
    } rsp_t;

    // True when the byte address is word aligned and falls inside a
    // scratchpad of 'depth' words. The compare is done at 34 bits so a
    // 4096-word limit (byte limit 0x4000) cannot overflow.
    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        logic [33:0] limit;
        limit = {2'b00, 32'(depth)} << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/vec_mem_rd_pipe.sv
// Fixed-latency read response pipeline.
//   clk, rst_n : clock, asynchronous active-low reset (drops in-flight reads)
//   rsp_in     : response captured at the request edge into stage 0
//   rsp_out    : last stage, presented READ_LATENCY cycles after the request
//   busy       : OR of all stage valid bits
// Data only moves into a stage alongside a valid entry, so the last stage
// keeps the most recently delivered word while no response is presented.
module vec_mem_rd_pipe
    import vec_mem_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  rsp_t rsp_in,
    output rsp_t rsp_out,
    output logic busy
);

    rsp_t stage_q [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0].valid <= rsp_in.valid;
            stage_q[0].err   <= rsp_in.err;
            if (rsp_in.valid) begin
                stage_q[0].data <= rsp_in.data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid;
                stage_q[i].err   <= stage_q[i-1].err;
                if (stage_q[i-1].valid) begin
                    stage_q[i].data <= stage_q[i-1].data;
                end
            end
        end
    end

    assign rsp_out = stage_q[READ_LATENCY-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/vector_mem_responder.sv
// Memory-side responder for the vector unit: word-addressed scratchpad
// with pipelined fixed-latency reads, single-cycle writes and bad-request
// flagging/counting.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem_addr    : byte address (word index = mem_addr[log2(DEPTH)+1:2])
//   mem_read    : read request, one word per cycle
//   mem_write   : write request
//   mem_wdata   : write data
//   mem_rdata   : read data, holds last delivered word between responses
//   mem_rvalid  : one-cycle response pulse
//   mem_err     : one-cycle pulse for a bad request (with response, or the
//                 cycle after a bad write)
//   busy        : any read in flight
//   err_count   : saturating count of bad requests
// The pipeline stage struct carries VM_DATA_WIDTH bits of data, so
// DATA_WIDTH is expected to stay at the package default.
module vector_mem_responder
    import vec_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = VM_DATA_WIDTH,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    output logic                  mem_err,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         idx;
    logic                  addr_good;
    logic                  wr_ok;
    logic                  wr_bad;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    rsp_t                  rsp_in;
    rsp_t                  rsp_out;
    logic                  wr_err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [1:0]            err_inc;
    logic [ERR_CNT_W:0]    err_sum;

    assign idx       = mem_addr[AW+1:2];
    assign addr_good = addr_ok(mem_addr, DEPTH);
    // A read+write conflict is handled entirely as a bad read.
    assign wr_ok     = mem_write && !mem_read && addr_good;
    assign wr_bad    = mem_write && !mem_read && !addr_good;

    // Storage is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    always_comb begin
        rsp_in = '0;
        if (mem_read) begin
            rsp_in.valid = 1'b1;
            if (!addr_good || mem_write) begin
                rsp_in.err = 1'b1;
            end else begin
                rsp_in.data = mem_q[idx];
            end
        end
    end

    vec_mem_rd_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .rsp_in (rsp_in),
        .rsp_out(rsp_out),
        .busy   (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
        end
    end

    // A bad-read response and a bad-write pulse can land in the same cycle;
    // both are counted.
    always_comb begin
        err_inc = {1'b0, rsp_out.valid & rsp_out.err} + {1'b0, wr_err_q};
        err_sum = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_sum[ERR_CNT_W]) begin
            err_cnt_q <= '1;
        end else begin
            err_cnt_q <= err_sum[ERR_CNT_W-1:0];
        end
    end

    assign mem_rvalid = rsp_out.valid;
    assign mem_rdata  = rsp_out.data;
    assign mem_err    = (rsp_out.valid & rsp_out.err) | wr_err_q;
    assign err_count  = err_cnt_q;

endmodule
